pu_tag_lookup_engine: RTL
=========================

PU_TAG_LOOKUP_ENGINE -- requirements
Module: pu_tag_lookup_engine

Interface
REQ-001 SHALL have parameter NUM_OF_PU, default `NUM_OF_PU, number of requesting PUs.
REQ-002 SHALL have parameter BKT_NBITS, default `TAG_BKT_NBITS, bucket index width; table address width is BKT_NBITS+3.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low (the codebase `RESET_SIG).
REQ-005 SHALL have port lookup_req  input  NUM_OF_PU  per-PU level request, held until lookup_ack.
REQ-006 SHALL have port lookup_tag[NUM_OF_PU]  input  `TAG_NBITS each  tag to search, stable while lookup_req high.
REQ-007 SHALL have port lookup_ack  output  NUM_OF_PU  one-cycle completion pulse to the granted PU.
REQ-008 SHALL have port tbl_rd  output  1  tag table read strobe.
REQ-009 SHALL have port tbl_raddr  output  BKT_NBITS+3  table address {bucket, entry[2:0]}.
REQ-010 SHALL have port tbl_rdata  input  1+`TAG_NBITS+`RCI_NBITS  {valid, tag, rci}, returned one cycle after tbl_rd.
REQ-011 SHALL have port tag_lookup_valid  output  1  one match result this cycle.
REQ-012 SHALL have port tag_lookup_result  output  `RCI_NBITS  RCI of matching entry.
REQ-013 SHALL have port tag_lookup_result_num  output  3  ordinal of this match within the lookup (0..7).
REQ-014 SHALL have port tag_lookup_result_pid  output  `PU_ID_NBITS  requesting PU.
REQ-015 SHALL have port tag_lookup_status_valid  output  1  lookup complete.
REQ-016 SHALL have port tag_lookup_status  output  4  total match count 0..8.
REQ-017 SHALL have port tag_lookup_status_pid  output  `PU_ID_NBITS  requesting PU.

Function
REQ-018 SHALL implement FSM states IDLE, SCAN, DRAIN, STATUS; one lookup in flight at a time.
REQ-019 IDLE: any lookup_req bit set in cycle T -> grant round-robin, latch pid and tag, enter SCAN at T+1.
REQ-020 Round-robin: search starts at PU after last granted; after reset starts at PU 0.
REQ-021 Bucket SHALL be lookup_tag[BKT_NBITS-1:0] of granted PU.
REQ-022 SCAN: cycles T+1..T+8 tbl_rd=1, tbl_raddr={bucket, 0..7} ascending; then DRAIN for T+9..T+10, STATUS at T+11, IDLE at T+12.
REQ-023 Entry matches when valid=1 and entry tag == latched tag; compare on tbl_rdata, result registered: match on read at cycle C -> tag_lookup_valid at C+2.
REQ-024 result_num SHALL equal number of earlier matches in same lookup; first match 0; counter 4 bits internally, output low 3 bits.
REQ-025 Eight matches SHALL all be emitted (result_num 0..7) and status=8.
REQ-026 tag_lookup_status_valid, status count, status_pid and lookup_ack[pid] SHALL pulse together in cycle T+11 only.
REQ-027 tag_lookup_valid and tag_lookup_status_valid SHALL never be high in the same cycle.
REQ-028 Outputs SHALL be zero whenever their valid is low.
REQ-029 Requests arriving while not IDLE SHALL wait; none dropped; new grant earliest T+12.
REQ-030 A PU's lookup_req low at its own ack cycle SHALL not be regranted; requests still high at T+12 compete normally.

Reset
REQ-031 rstn low SHALL asynchronously force FSM IDLE, rr pointer 0, match counter 0, and all outputs 0.
REQ-032 Reset mid-lookup SHALL abandon it with no status or ack; pending requests re-arbitrate after release.

Structure
REQ-033 FSM state enum and table entry struct {valid, tag, rci} SHALL live in type_package; TAG_BKT_NBITS in defines.vh.
REQ-034 Round-robin arbiter SHALL be sub-module pu_rr_arb (NUM_OF_PU req in, one-hot grant plus encoded id out).

Verification
REQ-035 PU2 tag 0x0015, bucket 5 entries 1,6 match -> results rci1 num0 at T+4, rci6 num1 at T+9; status=2 pid2 and ack[2] at T+11.
REQ-036 No match in bucket -> no tag_lookup_valid; status=0 and ack at T+11.
REQ-037 All 8 entries match -> valid T+3..T+10, num 0..7; status=8 at T+11.
REQ-038 PU0, PU1, PU3 request simultaneously -> grants 0,1,3 at T, T+12, T+24; acks in that order.
REQ-039 Matching entry with valid=0 -> ignored; status counts only valid matches.
REQ-040 rstn low at T+5 -> outputs 0 immediately, no status; after release pending request re-granted and completes normally.

Source files
------------

// File: rtl/pu_tag_lookup_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pu_tag_lookup_engine_pkg
//  Description : Shared widths, FSM state type and tag-table entry layout for
//                the PU tag lookup engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package pu_tag_lookup_engine_pkg;

    localparam int DEF_NUM_OF_PU     = 4;
    localparam int DEF_TAG_BKT_NBITS = 4;
    localparam int TAG_NBITS         = 16;
    localparam int RCI_NBITS         = 8;
    localparam int PU_ID_NBITS       = 2;

    // Lookup sequencing: grant, read 8 entries, let the read pipe empty, report.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_STATUS = 2'd3
    } lookup_state_t;

    // One tag-table word as returned by the table.
    typedef struct packed {
        logic                 valid;
        logic [TAG_NBITS-1:0] tag;
        logic [RCI_NBITS-1:0] rci;
    } tbl_entry_t;

endpackage : pu_tag_lookup_engine_pkg
`default_nettype wire

// File: rtl/pu_tag_lookup_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : pu_tag_lookup_engine_if
//  Description : PU request/ack, tag-table read port and result/status bus of
//                the tag lookup engine. The engine is the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pu_tag_lookup_engine_if
    import pu_tag_lookup_engine_pkg::*;
#(
    parameter int NUM_OF_PU = DEF_NUM_OF_PU,
    parameter int BKT_NBITS = DEF_TAG_BKT_NBITS
);

    logic [NUM_OF_PU-1:0]                lookup_req;
    logic [NUM_OF_PU-1:0][TAG_NBITS-1:0] lookup_tag;
    logic [NUM_OF_PU-1:0]                lookup_ack;

    logic                                tbl_rd;
    logic [BKT_NBITS+2:0]                tbl_raddr;
    tbl_entry_t                          tbl_rdata;

    logic                                tag_lookup_valid;
    logic [RCI_NBITS-1:0]                tag_lookup_result;
    logic [2:0]                          tag_lookup_result_num;
    logic [PU_ID_NBITS-1:0]              tag_lookup_result_pid;

    logic                                tag_lookup_status_valid;
    logic [3:0]                          tag_lookup_status;
    logic [PU_ID_NBITS-1:0]              tag_lookup_status_pid;

    modport slave (
        input  lookup_req, lookup_tag, tbl_rdata,
        output lookup_ack, tbl_rd, tbl_raddr,
        output tag_lookup_valid, tag_lookup_result, tag_lookup_result_num, tag_lookup_result_pid,
        output tag_lookup_status_valid, tag_lookup_status, tag_lookup_status_pid
    );

    modport master (
        output lookup_req, lookup_tag, tbl_rdata,
        input  lookup_ack, tbl_rd, tbl_raddr,
        input  tag_lookup_valid, tag_lookup_result, tag_lookup_result_num, tag_lookup_result_pid,
        input  tag_lookup_status_valid, tag_lookup_status, tag_lookup_status_pid
    );

endinterface : pu_tag_lookup_engine_if
`default_nettype wire

// File: rtl/pu_tag_lookup_engine_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : pu_rr_arb
//  Description : Round-robin arbiter. The search starts at the requester after
//                the last one granted; after reset it starts at requester 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_rr_arb #(
    parameter int NUM_OF_PU = 4,
    parameter int ID_NBITS  = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rstn,
    input  wire logic [NUM_OF_PU-1:0] i_req,
    input  wire logic                 i_advance,
    output logic      [NUM_OF_PU-1:0] o_gnt,
    output logic      [ID_NBITS-1:0]  o_gnt_id
);

    localparam logic [ID_NBITS:0]   c_num  = (ID_NBITS+1)'(NUM_OF_PU);
    localparam logic [ID_NBITS-1:0] c_last = ID_NBITS'(NUM_OF_PU - 1);

    logic [ID_NBITS-1:0] r_ptr;
    logic [ID_NBITS:0]   w_idx;
    logic                w_found;

    // Pick the first requester at or after the pointer, wrapping once.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_OF_PU; i++) begin
            w_idx = {1'b0, r_ptr} + (ID_NBITS+1)'(i);
            if (w_idx >= c_num) begin
                w_idx = w_idx - c_num;
            end
            if (!w_found && i_req[w_idx[ID_NBITS-1:0]]) begin
                w_found                     = 1'b1;
                o_gnt[w_idx[ID_NBITS-1:0]] = 1'b1;
                o_gnt_id                    = w_idx[ID_NBITS-1:0];
            end
        end
    end

    // Move the search start past the requester just granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_gnt_id == c_last) ? '0 : o_gnt_id + ID_NBITS'(1);
        end
    end

endmodule : pu_rr_arb
`default_nettype wire

// File: rtl/pu_tag_lookup_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pu_tag_lookup_engine
//  Description : Serves one PU tag lookup at a time: reads the 8 entries of the
//                tag's bucket, emits each valid match with its ordinal, then
//                reports the match count and acks the requesting PU.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_tag_lookup_engine
    import pu_tag_lookup_engine_pkg::*;
#(
    parameter int NUM_OF_PU = DEF_NUM_OF_PU,
    parameter int BKT_NBITS = DEF_TAG_BKT_NBITS
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    pu_tag_lookup_engine_if.slave bus
);

    localparam int c_addr_nbits = BKT_NBITS + 3;

    lookup_state_t            r_state;
    logic [PU_ID_NBITS-1:0]   r_pid;
    logic [NUM_OF_PU-1:0]     r_gnt;
    logic [TAG_NBITS-1:0]     r_tag;
    logic [2:0]               r_entry;
    logic                     r_drain;
    logic [3:0]               r_cnt;
    logic                     r_rd_d1;

    logic                     r_tbl_rd;
    logic [c_addr_nbits-1:0]  r_tbl_raddr;
    logic [NUM_OF_PU-1:0]     r_ack;
    logic                     r_res_valid;
    logic [RCI_NBITS-1:0]     r_res;
    logic [2:0]               r_res_num;
    logic [PU_ID_NBITS-1:0]   r_res_pid;
    logic                     r_sts_valid;
    logic [3:0]               r_sts;
    logic [PU_ID_NBITS-1:0]   r_sts_pid;

    logic [NUM_OF_PU-1:0]     w_gnt;
    logic [PU_ID_NBITS-1:0]   w_gnt_id;
    logic                     w_grant_en;
    logic                     w_match;
    logic [TAG_NBITS-1:0]     w_gnt_tag;
    logic [2:0]               w_next_entry;

    assign w_grant_en   = (r_state == ST_IDLE) && (|bus.lookup_req);
    assign w_gnt_tag    = bus.lookup_tag[w_gnt_id];
    assign w_next_entry = r_entry + 3'd1;
    // Read data is only meaningful the cycle after a strobe.
    assign w_match      = r_rd_d1 && bus.tbl_rdata.valid && (bus.tbl_rdata.tag == r_tag);

    pu_rr_arb #(
        .NUM_OF_PU (NUM_OF_PU),
        .ID_NBITS  (PU_ID_NBITS)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (bus.lookup_req),
        .i_advance (w_grant_en),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id)
    );

    // Lookup FSM together with its registered table-read, result and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_pid       <= '0;
            r_gnt       <= '0;
            r_tag       <= '0;
            r_entry     <= '0;
            r_drain     <= 1'b0;
            r_cnt       <= '0;
            r_rd_d1     <= 1'b0;
            r_tbl_rd    <= 1'b0;
            r_tbl_raddr <= '0;
            r_ack       <= '0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_res_num   <= '0;
            r_res_pid   <= '0;
            r_sts_valid <= 1'b0;
            r_sts       <= '0;
            r_sts_pid   <= '0;
        end else begin
            r_ack       <= '0;
            r_sts_valid <= 1'b0;
            r_sts       <= '0;
            r_sts_pid   <= '0;
            r_rd_d1     <= r_tbl_rd;

            // Ordinal is the number of matches already seen in this lookup.
            if (w_match) begin
                r_res_valid <= 1'b1;
                r_res       <= bus.tbl_rdata.rci;
                r_res_num   <= r_cnt[2:0];
                r_res_pid   <= r_pid;
                r_cnt       <= r_cnt + 4'd1;
            end else begin
                r_res_valid <= 1'b0;
                r_res       <= '0;
                r_res_num   <= '0;
                r_res_pid   <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_en) begin
                        r_pid       <= w_gnt_id;
                        r_gnt       <= w_gnt;
                        r_tag       <= w_gnt_tag;
                        r_cnt       <= '0;
                        r_entry     <= '0;
                        r_tbl_rd    <= 1'b1;
                        r_tbl_raddr <= {w_gnt_tag[BKT_NBITS-1:0], 3'd0};
                        r_state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_entry == 3'd7) begin
                        r_tbl_rd    <= 1'b0;
                        r_tbl_raddr <= '0;
                        r_drain     <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_entry     <= w_next_entry;
                        r_tbl_raddr <= {r_tag[BKT_NBITS-1:0], w_next_entry};
                    end
                end
                ST_DRAIN: begin
                    // Two cycles let the last read return and its result register.
                    if (r_drain) begin
                        r_sts_valid <= 1'b1;
                        r_sts       <= r_cnt;
                        r_sts_pid   <= r_pid;
                        r_ack       <= r_gnt;
                        r_state     <= ST_STATUS;
                    end else begin
                        r_drain     <= 1'b1;
                    end
                end
                ST_STATUS: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tbl_rd                  = r_tbl_rd;
    assign bus.tbl_raddr               = r_tbl_raddr;
    assign bus.lookup_ack              = r_ack;
    assign bus.tag_lookup_valid        = r_res_valid;
    assign bus.tag_lookup_result       = r_res;
    assign bus.tag_lookup_result_num   = r_res_num;
    assign bus.tag_lookup_result_pid   = r_res_pid;
    assign bus.tag_lookup_status_valid = r_sts_valid;
    assign bus.tag_lookup_status       = r_sts;
    assign bus.tag_lookup_status_pid   = r_sts_pid;

endmodule : pu_tag_lookup_engine
`default_nettype wire
